// File: rtl/eth_tx_sequencer.sv
// rtl/eth_tx_sequencer.sv - AXI-lite CSR sequencer for one Ethernet transmit (length, send, wait pkt_sent)
// Optional pkt_sent watchdog enabled by defining ETH_SEQ_TIMEOUT_EN.
module eth_tx_sequencer #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int CSR_LEN_ADDR  = 'h0C,
    parameter int CSR_SEND_ADDR = 'h10,
    parameter int MAX_LEN       = 1514,
    parameter int TIMEOUT_CYC   = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [15:0]         req_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    input  logic                pkt_sent
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_LEN    = 3'd1,
        B_LEN     = 3'd2,
        WR_GO     = 3'd3,
        B_GO      = 3'd4,
        WAIT_SENT = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                pkt_q, pkt_d;
    logic                armed_q, armed_d;
`ifdef ETH_SEQ_TIMEOUT_EN
    logic [15:0]         cnt_q, cnt_d;
`endif

    logic aw_hs, w_hs, len_bad;

    assign aw_hs   = awvalid_q & awready;
    assign w_hs    = wvalid_q & wready;
    assign len_bad = (req_len == 16'd0) || (req_len > 16'(MAX_LEN));

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        pkt_d     = pkt_sent;
        armed_d   = armed_q;
`ifdef ETH_SEQ_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = WR_LEN;
                        busy_d    = 1'b1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = ADDR_W'(CSR_LEN_ADDR);
                        wdata_d   = DATA_W'(req_len);
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            WR_LEN, WR_GO: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = (state_q == WR_LEN) ? B_LEN : B_GO;
                    bready_d = 1'b1;
                end
            end
            B_LEN, B_GO: begin
                if (bvalid) begin
                    bready_d = 1'b0;
                    if (bresp != 2'b00) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (state_q == B_LEN) begin
                        state_d   = WR_GO;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = ADDR_W'(CSR_SEND_ADDR);
                        wdata_d   = DATA_W'(1);
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d = WAIT_SENT;
                        armed_d = 1'b0;
`ifdef ETH_SEQ_TIMEOUT_EN
                        cnt_d   = 16'd0;
`endif
                    end
                end
            end
            WAIT_SENT: begin
                // armed only after pkt_sent has been seen low here, so a level already high on entry is ignored
                if (armed_q && pkt_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`ifdef ETH_SEQ_TIMEOUT_EN
                end else if (cnt_q + 16'd1 == 16'(TIMEOUT_CYC)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
`endif
                end else begin
                    armed_d = armed_q | ~pkt_q;
`ifdef ETH_SEQ_TIMEOUT_EN
                    cnt_d   = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            pkt_q       <= 1'b0;
            armed_q     <= 1'b0;
`ifdef ETH_SEQ_TIMEOUT_EN
            cnt_q       <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            pkt_q       <= pkt_d;
            armed_q     <= armed_d;
`ifdef ETH_SEQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign awaddr    = awaddr_q;
    assign wdata     = wdata_q;
    assign wstrb     = '1;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;

endmodule
